// File: rtl/truth_table_capture_if.sv
// Harness-side bundle for truth_table_capture.
// master: the harness / DUC side (drives start and duc_out).
// slave : the capture block (drives the DUC inputs and reports the code).
interface truth_table_capture_if #(
  parameter int NUM_INPUTS = 3
);
  localparam int CODE_W = 2**NUM_INPUTS;

  logic                  start;
  logic [NUM_INPUTS-1:0] duc_in;
  logic                  duc_out;
  logic                  busy;
  logic                  done;
  logic [CODE_W-1:0]     code;
  logic [CODE_W-1:0]     glitch_mask;

  modport master (
    output start, duc_out,
    input  duc_in, busy, done, code, glitch_mask
  );

  modport slave (
    input  start, duc_out,
    output duc_in, busy, done, code, glitch_mask
  );
endinterface

// File: rtl/truth_table_capture.sv
// truth_table_capture: sweeps an N-input combinational DUC through every input
// combination, holds each one for SETTLE_CYCLES, then samples duc_out into a
// hex truth-table code. Combination 0 lands in the MSB, so a 0xEC gate reads
// back as code = 8'hEC.
// Optional build macro TT_GLITCH_CHECK_EN: adds a shadow sample taken on the
// last settle cycle and flags combinations whose output moved between that
// cycle and the sample cycle in glitch_mask. Without it glitch_mask is 0.
module truth_table_capture #(
  parameter  int NUM_INPUTS    = 3,
  parameter  int SETTLE_CYCLES = 4,
  localparam int CODE_W        = 2**NUM_INPUTS
) (
  input  logic                    clk,
  input  logic                    rst,
  truth_table_capture_if.slave    bus
);

  // idx carries one guard bit above the combination width so the terminal
  // value CODE_W-1 is compared directly and never wraps.
  localparam int IDX_W = NUM_INPUTS + 1;
  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CODE_W-1:0] code_q, code_nxt;
  logic [CODE_W-1:0] sel;

`ifdef TT_GLITCH_CHECK_EN
  logic              shadow, shadow_nxt;
  logic [CODE_W-1:0] gmask, gmask_nxt;
`endif

  // State and datapath registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      code_q <= '0;
`ifdef TT_GLITCH_CHECK_EN
      shadow <= 1'b0;
      gmask  <= '0;
`endif
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      code_q <= code_nxt;
`ifdef TT_GLITCH_CHECK_EN
      shadow <= shadow_nxt;
      gmask  <= gmask_nxt;
`endif
    end
  end

  // Next-state and datapath update; sel is the one-hot code bit for idx.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    code_nxt  = code_q;
`ifdef TT_GLITCH_CHECK_EN
    shadow_nxt = shadow;
    gmask_nxt  = gmask;
`endif
    sel = CODE_W'(1) << (IDX_LAST - idx);

    case (state)
      IDLE: begin
        if (bus.start) begin
          idx_nxt   = '0;
          cnt_nxt   = '0;
          code_nxt  = '0;
`ifdef TT_GLITCH_CHECK_EN
          gmask_nxt = '0;
`endif
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
`ifdef TT_GLITCH_CHECK_EN
          shadow_nxt = bus.duc_out;
`endif
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        code_nxt = bus.duc_out ? (code_q | sel) : (code_q & ~sel);
`ifdef TT_GLITCH_CHECK_EN
        if (bus.duc_out != shadow) gmask_nxt = gmask | sel;
`endif
        if (idx == IDX_LAST) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 1'b1;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      DONE: begin
        // start here is deliberately dropped; a new sweep needs IDLE.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs; duc_in is only non-zero while a combination is applied.
  always_comb begin
    bus.busy   = (state == SETTLE) || (state == SAMPLE);
    bus.done   = (state == DONE);
    bus.duc_in = bus.busy ? idx[NUM_INPUTS-1:0] : '0;
    bus.code   = code_q;
`ifdef TT_GLITCH_CHECK_EN
    bus.glitch_mask = gmask;
`else
    bus.glitch_mask = '0;
`endif
  end

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture: 0xEC sweep with per-cycle stepping,
// constant DUCs, ignored starts, mid-sweep reset, glitch flagging and a
// 2-input XOR instance.
module tb_truth_table_capture;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  truth_table_capture_if #(.NUM_INPUTS(3)) bus ();
  truth_table_capture_if #(.NUM_INPUTS(2)) bus2 ();

  truth_table_capture #(.NUM_INPUTS(3), .SETTLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  truth_table_capture #(.NUM_INPUTS(2), .SETTLE_CYCLES(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // DUC models. mode 0 = 0xEC gate, 1 = constant 1, 2 = constant 0.
  int         mode;
  logic       ovr_en, ovr_val;
  logic [7:0] ec_tbl;
  logic       f;

  always_comb begin
    f = 1'b0;
    case (mode)
      0: f = ec_tbl[3'd7 - bus.duc_in];
      1: f = 1'b1;
      default: f = 1'b0;
    endcase
    bus.duc_out = ovr_en ? ovr_val : f;
  end

  assign bus2.duc_out = ^bus2.duc_in;

`ifdef TT_GLITCH_CHECK_EN
  localparam logic [7:0] GLITCH_EXP = 8'h40;
`else
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge that accepted start (E0).
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus2.start = 1'b0;
    mode = 0; ovr_en = 1'b0; ovr_val = 1'b0; ec_tbl = 8'hEC;
    tick(); tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.duc_in !== 3'd0 ||
        bus.code !== 8'h00 || bus.glitch_mask !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b duc_in=%0d code=%h gm=%h exp all 0",
               bus.busy, bus.done, bus.duc_in, bus.code, bus.glitch_mask);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b done=%b exp 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_ec_sweep();
    logic [2:0] exp_in;
    mode = 0;
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      exp_in = 3'(k / 5);
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.duc_in !== exp_in) begin
        errors++;
        $display("FAIL ec_step cyc=%0d busy=%b done=%b duc_in=%0d exp 1 0 %0d",
                 k + 1, bus.busy, bus.done, bus.duc_in, exp_in);
      end
      tick();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.duc_in !== 3'd0) begin
      errors++;
      $display("FAIL ec_done cyc41 done=%b busy=%b duc_in=%0d exp 1 0 0",
               bus.done, bus.busy, bus.duc_in);
    end
    checks++;
    if (bus.code !== 8'hEC || bus.glitch_mask !== 8'h00) begin
      errors++;
      $display("FAIL ec_code code=%h gm=%h exp ec 00", bus.code, bus.glitch_mask);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.code !== 8'hEC) begin
      errors++;
      $display("FAIL ec_hold done=%b code=%h exp 0 ec", bus.done, bus.code);
    end
  endtask

  task automatic test_constant();
    int n;
    for (int m = 1; m <= 2; m++) begin
      mode = m;
      pulse_start();
      n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      checks++;
      if (n !== 40) begin
        errors++;
        $display("FAIL const_latency mode=%0d waited=%0d exp 40", m, n);
      end
      checks++;
      if (bus.code !== ((m == 1) ? 8'hFF : 8'h00) || bus.glitch_mask !== 8'h00) begin
        errors++;
        $display("FAIL const_code mode=%0d code=%h gm=%h exp %h 00",
                 m, bus.code, bus.glitch_mask, (m == 1) ? 8'hFF : 8'h00);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int early = 0;
    mode = 0;
    pulse_start();
    for (int k = 1; k <= 40; k++) begin
      bus.start = (k == 3 || k == 20);
      tick();
      bus.start = 1'b0;
      if (k < 40 && bus.done === 1'b1) early++;
    end
    checks++;
    if (early !== 0 || bus.done !== 1'b1 || bus.code !== 8'hEC) begin
      errors++;
      $display("FAIL restart_ignored early=%0d done=%b code=%h exp 0 1 ec",
               early, bus.done, bus.code);
    end
    // start while in DONE must not open a new sweep.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.code !== 8'hEC) begin
      errors++;
      $display("FAIL start_in_done busy=%b done=%b code=%h exp 0 0 ec",
               bus.busy, bus.done, bus.code);
    end
  endtask

  task automatic test_rst_mid();
    int dones = 0;
    int n;
    mode = 0;
    pulse_start();
    repeat (14) tick();
    checks++;
    if (bus.code !== 8'hC0 || bus.duc_in !== 3'd2) begin
      errors++;
      $display("FAIL partial_code code=%h duc_in=%0d exp c0 2", bus.code, bus.duc_in);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.duc_in !== 3'd0 || bus.code !== 8'h00 ||
        bus.done !== 1'b0 || bus.glitch_mask !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid busy=%b duc_in=%0d code=%h done=%b gm=%h exp 0 0 00 0 00",
               bus.busy, bus.duc_in, bus.code, bus.done, bus.glitch_mask);
    end
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL rst_no_done activity=%0d exp 0", dones);
    end
    // start coincident with rst: reset wins, block stays idle.
    rst = 1'b1; bus.start = 1'b1;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL start_with_rst busy=%b done=%b exp 0 0", bus.busy, bus.done);
    end
    pulse_start();
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 40 || bus.code !== 8'hEC) begin
      errors++;
      $display("FAIL rst_resweep waited=%0d code=%h exp 40 ec", n, bus.code);
    end
    tick();
  endtask

  task automatic test_glitch();
    int n;
    mode = 0;
    pulse_start();
    repeat (9) tick();
    // Now in the SAMPLE cycle of combination 001; force the output low.
    ovr_en = 1'b1; ovr_val = 1'b0;
    tick();
    ovr_en = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 30 || bus.code !== 8'hAC) begin
      errors++;
      $display("FAIL glitch_code waited=%0d code=%h exp 30 ac", n, bus.code);
    end
    checks++;
    if (bus.glitch_mask !== GLITCH_EXP) begin
      errors++;
      $display("FAIL glitch_mask got=%h exp %h", bus.glitch_mask, GLITCH_EXP);
    end
    tick();
    // A fresh clean sweep clears the mask.
    mode = 1;
    pulse_start();
    checks++;
    if (bus.glitch_mask !== 8'h00 || bus.code !== 8'h00) begin
      errors++;
      $display("FAIL start_clears gm=%h code=%h exp 00 00", bus.glitch_mask, bus.code);
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (bus.code !== 8'hFF || bus.glitch_mask !== 8'h00) begin
      errors++;
      $display("FAIL clean_after_glitch code=%h gm=%h exp ff 00", bus.code, bus.glitch_mask);
    end
    tick();
  endtask

  task automatic test_n2_xor();
    int n;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    n = 0;
    while (bus2.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL xor_latency waited=%0d exp 20", n);
    end
    checks++;
    if (bus2.code !== 4'h6 || bus2.glitch_mask !== 4'h0) begin
      errors++;
      $display("FAIL xor_code code=%h gm=%h exp 6 0", bus2.code, bus2.glitch_mask);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_ec_sweep();
    test_constant();
    test_start_ignored();
    test_rst_mid();
    test_glitch();
    test_n2_xor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
